// File: rtl/voice_pkg.sv
// voice_pkg: allocator state type, default sizes and note-index width helper
package voice_pkg;
  typedef enum logic {SCAN, STEAL_GAP} alloc_state_t;
  localparam int DEF_NUM_KEYS = 8;
  localparam int DEF_NUM_VOICES = 4;
  function automatic int key_w(input int num_keys);
    return $clog2(num_keys);
  endfunction
endpackage

// File: rtl/voice_picker.sv
// voice_picker: lowest free voice and, with VOICE_ALLOC_STEAL_EN, oldest voice (lowest index on tie)
module voice_picker #(
  parameter int NUM_VOICES = 4,
  parameter int AGE_W = 4
) (
  input  logic [NUM_VOICES-1:0]         gate_in,
`ifdef VOICE_ALLOC_STEAL_EN
  input  logic [NUM_VOICES*AGE_W-1:0]   ages_in,
  output logic [$clog2(NUM_VOICES)-1:0] oldest_idx,
`endif
  output logic                          free_valid,
  output logic [$clog2(NUM_VOICES)-1:0] free_idx
);
  localparam int VW = $clog2(NUM_VOICES);
  always_comb begin
    free_valid = |(~gate_in);
    free_idx = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) free_idx = gate_in[i] ? free_idx : VW'(i);
  end
`ifdef VOICE_ALLOC_STEAL_EN
  logic [AGE_W-1:0] best;
  always_comb begin
    best = '0;
    oldest_idx = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      oldest_idx = (ages_in[i*AGE_W +: AGE_W] > best) ? VW'(i) : oldest_idx;
      best = (ages_in[i*AGE_W +: AGE_W] > best) ? ages_in[i*AGE_W +: AGE_W] : best;
    end
  end
`endif
endmodule

// File: rtl/voice_allocator.sv
// voice_allocator: round-robin key scan assigning notes to voices; VOICE_ALLOC_STEAL_EN steals the oldest voice when full
module voice_allocator
  import voice_pkg::*;
#(
  parameter int NUM_KEYS = DEF_NUM_KEYS,
  parameter int NUM_VOICES = DEF_NUM_VOICES,
  parameter int AGE_W = 4
) (
  input  logic                                  clk_in,
  input  logic                                  rst_in,
  input  logic [NUM_KEYS-1:0]                   key_gate_in,
  output logic [NUM_VOICES-1:0]                 voice_gate_out,
  output logic [NUM_VOICES-1:0]                 voice_trigger_out,
  output logic [NUM_VOICES*key_w(NUM_KEYS)-1:0] voice_note_out,
  output logic [$clog2(NUM_VOICES):0]           busy_count_out,
  output logic                                  drop_out
);
  localparam int KEY_W = key_w(NUM_KEYS);
  localparam int VW = $clog2(NUM_VOICES);
  localparam int BW = VW + 1;
  alloc_state_t state_q, state_d;
  logic [KEY_W-1:0] scan_q, scan_d, alloc_k;
  logic [NUM_KEYS-1:0] held_q, held_d;
  logic [NUM_VOICES-1:0] gate_q, gate_d, trig_q, trig_d;
  logic [NUM_VOICES*KEY_W-1:0] note_q, note_d;
  logic [NUM_VOICES*AGE_W-1:0] age_q, age_d;
  logic [BW-1:0] busy_q, busy_d;
  logic drop_q, drop_d, alloc, free_valid;
  logic [VW-1:0] free_idx, alloc_v;
`ifdef VOICE_ALLOC_STEAL_EN
  logic [VW-1:0] oldest_idx, victim_q, victim_d;
  logic [KEY_W-1:0] steal_key_q, steal_key_d;
`endif
  voice_picker #(.NUM_VOICES(NUM_VOICES), .AGE_W(AGE_W)) u_picker (
    .gate_in(gate_q),
`ifdef VOICE_ALLOC_STEAL_EN
    .ages_in(age_q),
    .oldest_idx(oldest_idx),
`endif
    .free_valid(free_valid),
    .free_idx(free_idx)
  );
  always_comb begin
    state_d = state_q;
    scan_d = scan_q;
    held_d = held_q;
    gate_d = gate_q;
    trig_d = '0;
    note_d = note_q;
    age_d = age_q;
    drop_d = 1'b0;
    alloc = 1'b0;
    alloc_v = free_idx;
    alloc_k = scan_q;
`ifdef VOICE_ALLOC_STEAL_EN
    victim_d = victim_q;
    steal_key_d = steal_key_q;
`endif
    if (state_q == SCAN) begin
      scan_d = scan_q + KEY_W'(1);
      if (key_gate_in[scan_q] && !held_q[scan_q]) begin
        held_d[scan_q] = 1'b1;
        if (free_valid) alloc = 1'b1;
`ifdef VOICE_ALLOC_STEAL_EN
        else begin
          state_d = STEAL_GAP;
          scan_d = scan_q;
          victim_d = oldest_idx;
          steal_key_d = scan_q;
          gate_d[oldest_idx] = 1'b0;
        end
`else
        else drop_d = 1'b1;
`endif
      end else if (!key_gate_in[scan_q] && held_q[scan_q]) begin
        held_d[scan_q] = 1'b0;
        for (int v = 0; v < NUM_VOICES; v++)
          gate_d[v] = (gate_q[v] && note_q[v*KEY_W +: KEY_W] == scan_q) ? 1'b0 : gate_q[v];
      end
    end
`ifdef VOICE_ALLOC_STEAL_EN
    else begin
      state_d = SCAN;
      scan_d = scan_q + KEY_W'(1);
      alloc = 1'b1;
      alloc_v = victim_q;
      alloc_k = steal_key_q;
    end
`endif
    if (alloc) begin
      for (int v = 0; v < NUM_VOICES; v++)
        age_d[v*AGE_W +: AGE_W] = (gate_q[v] && !(&age_q[v*AGE_W +: AGE_W])) ?
          age_q[v*AGE_W +: AGE_W] + AGE_W'(1) : age_q[v*AGE_W +: AGE_W];
      gate_d[alloc_v] = 1'b1;
      trig_d[alloc_v] = 1'b1;
      note_d[int'(alloc_v)*KEY_W +: KEY_W] = alloc_k;
      age_d[int'(alloc_v)*AGE_W +: AGE_W] = '0;
    end
    busy_d = '0;
    for (int v = 0; v < NUM_VOICES; v++) busy_d = busy_d + BW'(gate_d[v]);
  end
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q <= SCAN;
      scan_q <= '0;
      held_q <= '0;
      gate_q <= '0;
      trig_q <= '0;
      note_q <= '0;
      age_q <= '0;
      busy_q <= '0;
      drop_q <= 1'b0;
`ifdef VOICE_ALLOC_STEAL_EN
      victim_q <= '0;
      steal_key_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      scan_q <= scan_d;
      held_q <= held_d;
      gate_q <= gate_d;
      trig_q <= trig_d;
      note_q <= note_d;
      age_q <= age_d;
      busy_q <= busy_d;
      drop_q <= drop_d;
`ifdef VOICE_ALLOC_STEAL_EN
      victim_q <= victim_d;
      steal_key_q <= steal_key_d;
`endif
    end
  end
  assign voice_gate_out = gate_q;
  assign voice_trigger_out = trig_q;
  assign voice_note_out = note_q;
  assign busy_count_out = busy_q;
  assign drop_out = drop_q;
endmodule

// File: tb/tb_voice_allocator.sv
// tb_voice_allocator: directed and random key stimulus checked each cycle against a behavioural voice model
module tb_voice_allocator;
  localparam int NK = 8;
  localparam int NV = 4;
  localparam int KW = 3;
  localparam int AW = 4;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [NK-1:0] keys = '0;
  logic [NV-1:0] gate, trig;
  logic [NV*KW-1:0] note;
  logic [2:0] busy;
  logic drop;
  int vectors = 0;
  int errs = 0;
  int n;
  always #5 clk = ~clk;
  voice_allocator dut (
    .clk_in(clk),
    .rst_in(rst),
    .key_gate_in(keys),
    .voice_gate_out(gate),
    .voice_trigger_out(trig),
    .voice_note_out(note),
    .busy_count_out(busy),
    .drop_out(drop)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  bit m_gate[NV], m_trig[NV], m_held[NK], m_gap, m_drop;
  int m_note[NV], m_age[NV];
  int m_scan, m_vic, m_skey, mk, mv;
  function automatic void m_assign(input int v, input int k);
    for (int u = 0; u < NV; u++)
      if (u != v && m_gate[u] && m_age[u] < (1 << AW) - 1) m_age[u]++;
    m_gate[v] = 1; m_trig[v] = 1; m_note[v] = k; m_age[v] = 0;
  endfunction
  always @(posedge clk) begin
    for (int v = 0; v < NV; v++) m_trig[v] = 0;
    m_drop = 0;
    if (!rst) begin
      for (int v = 0; v < NV; v++) begin m_gate[v] = 0; m_note[v] = 0; m_age[v] = 0; end
      for (int k = 0; k < NK; k++) m_held[k] = 0;
      m_scan = 0; m_gap = 0;
    end else if (m_gap) begin
      m_gap = 0;
      m_assign(m_vic, m_skey);
      m_scan = (m_scan + 1) % NK;
    end else begin
      mk = m_scan;
      if (keys[mk] && !m_held[mk]) begin
        m_held[mk] = 1;
        mv = -1;
        for (int v = NV - 1; v >= 0; v--) if (!m_gate[v]) mv = v;
        if (mv >= 0) m_assign(mv, mk);
        else begin
`ifdef VOICE_ALLOC_STEAL_EN
          m_vic = 0;
          for (int v = 1; v < NV; v++) if (m_age[v] > m_age[m_vic]) m_vic = v;
          m_gate[m_vic] = 0; m_gap = 1; m_skey = mk;
`else
          m_drop = 1;
`endif
        end
      end else if (!keys[mk] && m_held[mk]) begin
        m_held[mk] = 0;
        for (int v = 0; v < NV; v++) if (m_gate[v] && m_note[v] == mk) m_gate[v] = 0;
      end
      if (!m_gap) m_scan = (mk + 1) % NK;
    end
  end
  logic [NV-1:0] eg, et;
  logic [NV*KW-1:0] en;
  int eb;
  always @(negedge clk) begin
    eb = 0;
    for (int v = 0; v < NV; v++) begin
      eg[v] = m_gate[v]; et[v] = m_trig[v]; en[v*KW +: KW] = KW'(m_note[v]); eb += int'(m_gate[v]);
    end
    chk("gate", 32'(gate), 32'(eg));
    chk("trigger", 32'(trig), 32'(et));
    chk("note", 32'(note), 32'(en));
    chk("busy", 32'(busy), 32'(eb));
    chk("drop", 32'(drop), 32'(m_drop));
    chk("trig_without_gate", 32'(trig & ~gate), 0);
  end
  initial begin
    rst = 1'b0; keys = '1;
    repeat (3) @(negedge clk);
    chk("rst_gate", 32'(gate), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_note", 32'(note), 0);
    rst = 1'b1;
    @(negedge clk);
    chk("alloc0_trig", 32'(trig), 32'b0001);
    chk("alloc0_note", 32'(note[2:0]), 0);
    @(negedge clk);
    chk("alloc1_gate", 32'(gate), 32'b0011);
    repeat (2) @(negedge clk);
    chk("full_gate", 32'(gate), 32'hF);
    chk("full_notes", 32'(note), 32'h688);
    chk("full_busy", 32'(busy), 4);
    @(negedge clk);
`ifdef VOICE_ALLOC_STEAL_EN
    chk("gap_gate", 32'(gate), 32'b1110);
    chk("gap_trig", 32'(trig), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("midsteal_rst_gate", 32'(gate), 0);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    chk("rescan_gate", 32'(gate), 32'hF);
    chk("rescan_notes", 32'(note), 32'h688);
    @(negedge clk);
    chk("gap2_gate", 32'(gate), 32'b1110);
    @(negedge clk);
    chk("steal_gate", 32'(gate), 32'hF);
    chk("steal_trig", 32'(trig), 32'b0001);
    chk("steal_note", 32'(note[2:0]), 4);
    keys = 8'h1E;
    repeat (4) @(negedge clk);
    chk("stolen_release_notes", 32'(note), 32'h68C);
    chk("stolen_release_gate", 32'(gate), 32'hF);
`else
    chk("drop_pulse", 32'(drop), 1);
    chk("drop_gate", 32'(gate), 32'hF);
    chk("drop_trig", 32'(trig), 0);
    chk("drop_notes", 32'(note), 32'h688);
    keys = 8'h1F;
    n = 0;
    repeat (10) begin @(negedge clk); n += int'(drop); end
    chk("no_repeat_drop", 32'(n), 0);
`endif
    rst = 1'b0; keys = '0;
    @(negedge clk);
    rst = 1'b1; keys = 8'h20;
    n = 0;
    while (gate[0] !== 1'b1 && n < NK + 4) begin @(negedge clk); n++; end
    chk("single_latency_ok", 32'(n <= NK), 1);
    chk("single_note", 32'(note[2:0]), 5);
    chk("single_busy", 32'(busy), 1);
    repeat (40) @(negedge clk);
    keys = '0;
    n = 0;
    while (gate !== '0 && n < NK + 4) begin @(negedge clk); n++; end
    chk("release_latency_ok", 32'(n <= NK), 1);
    chk("release_busy", 32'(busy), 0);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1; keys = 8'h07;
    repeat (10) @(negedge clk);
    keys = 8'h05;
    repeat (10) @(negedge clk);
    keys = 8'h85;
    repeat (10) @(negedge clk);
    chk("reuse_gate", 32'(gate), 32'b0101 | 32'b0010);
    chk("reuse_v1_note", 32'(note[5:3]), 7);
    chk("reuse_v0_note", 32'(note[2:0]), 0);
    chk("reuse_v2_note", 32'(note[8:6]), 2);
    repeat (4000) begin
      @(negedge clk);
      for (int k = 0; k < NK; k++) if ($urandom_range(0, 39) == 0) keys[k] = ~keys[k];
      rst = ($urandom_range(0, 599) != 0);
    end
    rst = 1'b1;
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
